lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store sequencer between the exec stage's memory request outputs and a single-port data memory bus. It captures one read or write request per exec instruction and holds the pipeline with STALL until the bus transaction completes. It then returns load data, aligned and sign/zero-extended, as a one-cycle register write-back. It sits beside exec and drives the shared pipeline STALL together with the other hazard sources.

## Interface
Parameters:
- TIMEOUT_CYCLES, 256: bus wait limit in cycles; used only when LSU_TIMEOUT_EN is defined; legal range 1..65535.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- FLUSH  in  1  pipeline flush; discards the result of the in-flight request.
- MEM_R_VALID / MEM_R_RD / MEM_R_ADDR / MEM_R_STRB / MEM_R_SIGNED  in  1/5/32/4/1  load request from exec.
- MEM_W_VALID / MEM_W_ADDR / MEM_W_STRB / MEM_W_DATA  in  1/32/4/32  store request from exec.
- STALL  out  1  pipeline hold request; combinational.
- REG_W_RD / REG_W_DATA  out  5/32  load write-back; RD=0 means no write.
- BUS_VALID / BUS_WE / BUS_ADDR / BUS_STRB / BUS_WDATA  out  1/1/32/4/32  memory bus request; registered.
- BUS_READY / BUS_RDATA  in  1/32  bus completion, with read data on the same cycle.
- ERR  out  1  one-cycle pulse on bus timeout.

## Operation
- FSM has three states: IDLE, BUS, DONE. Reset puts it in IDLE. All outputs are 0 in reset; STALL is 0 after reset.
- IDLE transitions:
  - With MEM_R_VALID or MEM_W_VALID set and FLUSH low, capture the request and go to BUS.
  - Capture fields: addr, strb, wdata, we, rd, signed.
  - If both valids are set, the read wins and the write is dropped. Exec never issues both at once.
- BUS:
  - BUS_* outputs drive the captured request and BUS_VALID=1.
  - On BUS_READY=1: register the aligned load data, drop BUS_VALID, go to DONE.
- DONE:
  - For a load, REG_W_RD=captured rd and REG_W_DATA=aligned data.
  - For a store, or for a killed request, REG_W_RD=0 and REG_W_DATA=0.
  - Request inputs are ignored, because exec still presents the completed instruction this cycle.
  - Next state is IDLE unconditionally.
- STALL:
  - STALL = (IDLE and a request is valid and not FLUSH) or (state==BUS).
  - STALL is 0 in DONE.
- REG_W_RD and REG_W_DATA are 0 in every state except DONE.
- Load alignment, driven by strobe:
  - Offset = index of the lowest set bit of STRB. Width = popcount(STRB): 1 is a byte, 2 is a halfword, otherwise a word.
  - Data = BUS_RDATA >> (8*offset), truncated to that width.
  - The result is sign-extended if SIGNED, zero-extended otherwise.
  - Strobe 4'b1000 (truncated shifted halfword) is handled as a byte at lane 3.
  - Strobe 0 produces REG_W_DATA=0.
- FLUSH while in BUS: the bus transaction completes normally, since the bus cannot be aborted. A kill flag is set, and DONE writes back RD=0.
- FLUSH in DONE has no effect. FLUSH in IDLE blocks request capture.
- RST mid-transaction: on the next edge the FSM goes to IDLE with BUS_VALID=0 and all outputs 0. The memory side must tolerate the abandoned request.
- BUS_ADDR is passed through unmodified. Exec has already word-aligned it.

## Timing
- Load/store minimum occupancy is 3 cycles:
  - C0: IDLE, request seen, STALL=1.
  - C1: BUS, BUS_VALID=1, BUS_READY=1, STALL=1.
  - C2: DONE, write-back valid, STALL=0.
- Each cycle of BUS_READY=0 in BUS adds one cycle. BUS_VALID and the BUS_* fields are stable until READY.
- A request in the cycle after DONE is accepted normally; the back-to-back throughput is 1 access per 3 cycles.
- ERR is a 1-cycle pulse coincident with DONE.

## Configuration
- LSU_TIMEOUT_EN defined:
  - A 16-bit counter clears on entry to BUS and increments each BUS cycle without READY.
  - When the count reaches TIMEOUT_CYCLES, the block drops BUS_VALID, enters DONE with RD=0, and pulses ERR.
- LSU_TIMEOUT_EN undefined:
  - No counter exists; the block waits indefinitely in BUS.
  - ERR is tied to 0.

## Test plan
- LB, sign-extended: MEM_R_VALID, RD=5, STRB=4'b0100, SIGNED=1, READY in first BUS cycle, RDATA=32'h0080_0000. Required: STALL high for 2 cycles, then REG_W_RD=5 and REG_W_DATA=32'hFFFF_FF80 for exactly 1 cycle.
- LHU, zero-extended: STRB=4'b1100, SIGNED=0, RDATA=32'h8001_0000, READY delayed 3 cycles. Required: STALL high for 5 cycles, then REG_W_DATA=32'h0000_8001.
- SW: ADDR=32'h100, DATA=32'hDEAD_BEEF, STRB=4'hF. Required: BUS_WE=1 with all fields held until READY, then DONE with REG_W_RD=0.
- FLUSH pulse in BUS during a load with RD=7. Required: the bus completes, DONE gives REG_W_RD=0, and no re-issue occurs while MEM_R_VALID stays high in DONE.
- RST asserted in BUS. Required: BUS_VALID=0, STALL=0, and outputs 0 on the next cycle.
- With LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, READY never asserted. Required: ERR pulses after 4 BUS cycles, BUS_VALID drops, STALL releases.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: captures one exec memory request, runs it on a single-port bus,
// and returns aligned load data as a one-cycle write-back. Optional bus timeout: LSU_TIMEOUT_EN.
module lsu_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        FLUSH,
    input  logic        MEM_R_VALID,
    input  logic [4:0]  MEM_R_RD,
    input  logic [31:0] MEM_R_ADDR,
    input  logic [3:0]  MEM_R_STRB,
    input  logic        MEM_R_SIGNED,
    input  logic        MEM_W_VALID,
    input  logic [31:0] MEM_W_ADDR,
    input  logic [3:0]  MEM_W_STRB,
    input  logic [31:0] MEM_W_DATA,
    output logic        STALL,
    output logic [4:0]  REG_W_RD,
    output logic [31:0] REG_W_DATA,
    output logic        BUS_VALID,
    output logic        BUS_WE,
    output logic [31:0] BUS_ADDR,
    output logic [3:0]  BUS_STRB,
    output logic [31:0] BUS_WDATA,
    input  logic        BUS_READY,
    input  logic [31:0] BUS_RDATA,
    output logic        ERR
);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t      state, state_next;
    logic [4:0]  cap_rd;
    logic        cap_signed;
    logic        kill;
    logic [31:0] load_data;
    logic [31:0] aligned;
    logic [1:0]  lane;
    logic [2:0]  ones;
    logic [31:0] shifted;
    logic        req_take;
    logic        bus_done;
    logic        timeout;
    logic        timed_out;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout_range
    end

    assign req_take = (state == IDLE) && (MEM_R_VALID || MEM_W_VALID) && !FLUSH;
    assign bus_done = (state == BUS) && BUS_READY;

`ifdef LSU_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] wait_cnt;

    assign timeout = (state == BUS) && !BUS_READY && (wait_cnt == TIMEOUT_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            wait_cnt  <= '0;
            timed_out <= 1'b0;
        end else begin
            if (req_take) begin
                wait_cnt  <= '0;
                timed_out <= 1'b0;
            end else if (state == BUS && !BUS_READY) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
            if (timeout)
                timed_out <= 1'b1;
        end
    end

    assign ERR = (state == DONE) && timed_out;
`else
    assign timeout   = 1'b0;
    assign timed_out = 1'b0;
    assign ERR       = 1'b0;
`endif

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        STALL      = 1'b0;
        case (state)
            IDLE: begin
                if (req_take) begin
                    state_next = BUS;
                    STALL      = 1'b1;
                end
            end
            BUS: begin
                STALL = 1'b1;
                if (bus_done || timeout)
                    state_next = DONE;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Lowest strobe lane picks the offset, strobe popcount picks byte/halfword/word.
    always_comb begin
        lane = 2'd0;
        casez (BUS_STRB)
            4'b???1: lane = 2'd0;
            4'b??10: lane = 2'd1;
            4'b?100: lane = 2'd2;
            4'b1000: lane = 2'd3;
            default: lane = 2'd0;
        endcase
        ones    = {2'b00, BUS_STRB[0]} + {2'b00, BUS_STRB[1]}
                + {2'b00, BUS_STRB[2]} + {2'b00, BUS_STRB[3]};
        shifted = BUS_RDATA >> {lane, 3'b000};
        case (ones)
            3'd0:    aligned = 32'd0;
            3'd1:    aligned = {{24{cap_signed & shifted[7]}}, shifted[7:0]};
            3'd2:    aligned = {{16{cap_signed & shifted[15]}}, shifted[15:0]};
            default: aligned = shifted;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= IDLE;
            BUS_VALID  <= 1'b0;
            BUS_WE     <= 1'b0;
            BUS_ADDR   <= '0;
            BUS_STRB   <= '0;
            BUS_WDATA  <= '0;
            cap_rd     <= '0;
            cap_signed <= 1'b0;
            kill       <= 1'b0;
            load_data  <= '0;
        end else begin
            state <= state_next;
            if (req_take) begin
                BUS_VALID  <= 1'b1;
                BUS_WDATA  <= MEM_W_DATA;
                cap_rd     <= MEM_R_RD;
                cap_signed <= MEM_R_SIGNED;
                kill       <= 1'b0;
                if (MEM_R_VALID) begin
                    BUS_WE   <= 1'b0;
                    BUS_ADDR <= MEM_R_ADDR;
                    BUS_STRB <= MEM_R_STRB;
                end else begin
                    BUS_WE   <= 1'b1;
                    BUS_ADDR <= MEM_W_ADDR;
                    BUS_STRB <= MEM_W_STRB;
                end
            end
            // The bus cannot be aborted, so a flush only suppresses the write-back.
            if (state == BUS && FLUSH)
                kill <= 1'b1;
            if (bus_done) begin
                BUS_VALID <= 1'b0;
                load_data <= aligned;
            end else if (timeout) begin
                BUS_VALID <= 1'b0;
            end
        end
    end

    always_comb begin
        REG_W_RD   = 5'd0;
        REG_W_DATA = 32'd0;
        if (state == DONE && !BUS_WE && !kill && !timed_out) begin
            REG_W_RD   = cap_rd;
            REG_W_DATA = load_data;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed scenarios plus randomized transactions
// checked against a transaction-level reference model.
module tb_lsu_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        FLUSH;
    logic        MEM_R_VALID;
    logic [4:0]  MEM_R_RD;
    logic [31:0] MEM_R_ADDR;
    logic [3:0]  MEM_R_STRB;
    logic        MEM_R_SIGNED;
    logic        MEM_W_VALID;
    logic [31:0] MEM_W_ADDR;
    logic [3:0]  MEM_W_STRB;
    logic [31:0] MEM_W_DATA;
    logic        STALL;
    logic [4:0]  REG_W_RD;
    logic [31:0] REG_W_DATA;
    logic        BUS_VALID;
    logic        BUS_WE;
    logic [31:0] BUS_ADDR;
    logic [3:0]  BUS_STRB;
    logic [31:0] BUS_WDATA;
    logic        BUS_READY;
    logic [31:0] BUS_RDATA;
    logic        ERR;

    int n_cmp = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
        .MEM_R_VALID(MEM_R_VALID), .MEM_R_RD(MEM_R_RD), .MEM_R_ADDR(MEM_R_ADDR),
        .MEM_R_STRB(MEM_R_STRB), .MEM_R_SIGNED(MEM_R_SIGNED),
        .MEM_W_VALID(MEM_W_VALID), .MEM_W_ADDR(MEM_W_ADDR), .MEM_W_STRB(MEM_W_STRB),
        .MEM_W_DATA(MEM_W_DATA),
        .STALL(STALL), .REG_W_RD(REG_W_RD), .REG_W_DATA(REG_W_DATA),
        .BUS_VALID(BUS_VALID), .BUS_WE(BUS_WE), .BUS_ADDR(BUS_ADDR),
        .BUS_STRB(BUS_STRB), .BUS_WDATA(BUS_WDATA),
        .BUS_READY(BUS_READY), .BUS_RDATA(BUS_RDATA), .ERR(ERR)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference alignment: pick lanes by strobe, then extend.
    function automatic logic [31:0] ref_align(input logic [31:0] data, input logic [3:0] strb,
                                              input bit sgn);
        int off = -1;
        int n = 0;
        int nbytes;
        logic [31:0] v;
        logic [31:0] res;
        for (int i = 0; i < 4; i++)
            if (strb[i]) begin
                n++;
                if (off < 0) off = i;
            end
        if (n == 0) return 32'd0;
        nbytes = (n == 1) ? 1 : (n == 2) ? 2 : 4;
        v   = data >> (8 * off);
        res = 32'd0;
        for (int b = 0; b < nbytes; b++) res[8*b +: 8] = v[8*b +: 8];
        if (sgn && nbytes < 4 && v[8*nbytes-1])
            for (int b = nbytes; b < 4; b++) res[8*b +: 8] = 8'hFF;
        return res;
    endfunction

    task automatic idle_inputs();
        MEM_R_VALID = 1'b0; MEM_W_VALID = 1'b0; FLUSH = 1'b0; BUS_READY = 1'b0;
    endtask

    // One full transaction: C0 in IDLE, delay+1 cycles in BUS, one DONE cycle, one IDLE cycle.
    task automatic run_req(input string tag, input bit is_load, input bit both,
                           input logic [4:0] rd, input logic [31:0] addr, input logic [3:0] strb,
                           input logic [31:0] wdata, input bit sgn, input logic [31:0] rdata,
                           input int delay, input int flush_at);
        bit killed;
        logic [31:0] exp_data;
        killed   = (flush_at >= 0) && (flush_at <= delay);
        exp_data = (is_load && !killed) ? ref_align(rdata, strb, sgn) : 32'd0;

        @(posedge CLK); #1;
        MEM_R_VALID  = is_load;
        MEM_W_VALID  = !is_load || both;
        MEM_R_RD     = rd;
        MEM_R_ADDR   = is_load ? addr : $urandom;
        MEM_R_STRB   = is_load ? strb : 4'($urandom);
        MEM_R_SIGNED = sgn;
        MEM_W_ADDR   = is_load ? $urandom : addr;
        MEM_W_STRB   = is_load ? 4'($urandom) : strb;
        MEM_W_DATA   = wdata;
        BUS_READY    = 1'b0;
        FLUSH        = 1'b0;
        @(negedge CLK);
        check({tag, "_c0_stall"}, 32'(STALL), 32'd1);
        check({tag, "_c0_bus_valid"}, 32'(BUS_VALID), 32'd0);

        for (int i = 0; i <= delay; i++) begin
            @(posedge CLK); #1;
            BUS_READY = (i == delay);
            BUS_RDATA = (i == delay) ? rdata : $urandom;
            FLUSH     = (i == flush_at);
            @(negedge CLK);
            check({tag, "_bus_stall"}, 32'(STALL), 32'd1);
            check({tag, "_bus_valid"}, 32'(BUS_VALID), 32'd1);
            check({tag, "_bus_we"}, 32'(BUS_WE), 32'(!is_load));
            check({tag, "_bus_addr"}, BUS_ADDR, addr);
            check({tag, "_bus_strb"}, 32'(BUS_STRB), 32'(strb));
            check({tag, "_bus_wdata"}, BUS_WDATA, wdata);
            check({tag, "_bus_rd_zero"}, 32'(REG_W_RD), 32'd0);
            check({tag, "_bus_err"}, 32'(ERR), 32'd0);
        end

        @(posedge CLK); #1;
        BUS_READY = 1'b0;
        BUS_RDATA = $urandom;
        FLUSH     = 1'($urandom_range(0, 1));
        @(negedge CLK);
        check({tag, "_done_stall"}, 32'(STALL), 32'd0);
        check({tag, "_done_bus_valid"}, 32'(BUS_VALID), 32'd0);
        check({tag, "_done_rd"}, 32'(REG_W_RD), (is_load && !killed) ? 32'(rd) : 32'd0);
        check({tag, "_done_data"}, REG_W_DATA, exp_data);
        check({tag, "_done_err"}, 32'(ERR), 32'd0);

        @(posedge CLK); #1;
        idle_inputs();
        @(negedge CLK);
        check({tag, "_after_stall"}, 32'(STALL), 32'd0);
        check({tag, "_after_bus_valid"}, 32'(BUS_VALID), 32'd0);
        check({tag, "_after_rd"}, 32'(REG_W_RD), 32'd0);
    endtask

    initial begin
        RST = 1'b1;
        idle_inputs();
        MEM_R_RD = '0; MEM_R_ADDR = '0; MEM_R_STRB = '0; MEM_R_SIGNED = 1'b0;
        MEM_W_ADDR = '0; MEM_W_STRB = '0; MEM_W_DATA = '0; BUS_RDATA = '0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_stall", 32'(STALL), 32'd0);
        check("rst_bus_valid", 32'(BUS_VALID), 32'd0);
        check("rst_bus_addr", BUS_ADDR, 32'd0);
        check("rst_rd", 32'(REG_W_RD), 32'd0);
        check("rst_data", REG_W_DATA, 32'd0);
        check("rst_err", 32'(ERR), 32'd0);
        @(posedge CLK); #1;
        RST = 1'b0;

        run_req("lb_signed", 1'b1, 1'b0, 5'd5, 32'h0000_0040, 4'b0100, 32'h0, 1'b1,
                32'h0080_0000, 0, -1);
        check("lb_model_value", ref_align(32'h0080_0000, 4'b0100, 1'b1), 32'hFFFF_FF80);
        run_req("lhu_delay3", 1'b1, 1'b0, 5'd9, 32'h0000_0080, 4'b1100, 32'h0, 1'b0,
                32'h8001_0000, 3, -1);
        run_req("sw", 1'b0, 1'b0, 5'd3, 32'h0000_0100, 4'hF, 32'hDEAD_BEEF, 1'b0,
                32'h1234_5678, 2, -1);
        run_req("flush_load", 1'b1, 1'b0, 5'd7, 32'h0000_0200, 4'hF, 32'h0, 1'b0,
                32'hCAFE_F00D, 2, 1);
        run_req("both_valid", 1'b1, 1'b1, 5'd11, 32'h0000_0300, 4'b0011, 32'h5555_AAAA, 1'b1,
                32'h0000_9ABC, 1, -1);
        run_req("strb_zero", 1'b1, 1'b0, 5'd12, 32'h0000_0400, 4'b0000, 32'h0, 1'b1,
                32'hFFFF_FFFF, 0, -1);
        run_req("strb_1000", 1'b1, 1'b0, 5'd13, 32'h0000_0500, 4'b1000, 32'h0, 1'b1,
                32'h9000_0000, 0, -1);

        // Reset asserted while the request sits in BUS.
        @(posedge CLK); #1;
        MEM_R_VALID = 1'b1; MEM_R_RD = 5'd4; MEM_R_ADDR = 32'h0000_0600;
        MEM_R_STRB = 4'hF; MEM_R_SIGNED = 1'b0;
        @(posedge CLK); #1;
        idle_inputs();
        RST = 1'b1;
        @(negedge CLK);
        check("rstbus_pre_valid", 32'(BUS_VALID), 32'd1);
        @(posedge CLK); #1;
        RST = 1'b0;
        @(negedge CLK);
        check("rstbus_valid", 32'(BUS_VALID), 32'd0);
        check("rstbus_stall", 32'(STALL), 32'd0);
        check("rstbus_addr", BUS_ADDR, 32'd0);
        check("rstbus_we", 32'(BUS_WE), 32'd0);
        check("rstbus_rd", 32'(REG_W_RD), 32'd0);
        check("rstbus_data", REG_W_DATA, 32'd0);

`ifdef LSU_TIMEOUT_EN
        @(posedge CLK); #1;
        MEM_R_VALID = 1'b1; MEM_R_RD = 5'd6; MEM_R_ADDR = 32'h0000_0700; MEM_R_STRB = 4'hF;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            @(negedge CLK);
            check("to_bus_valid", 32'(BUS_VALID), 32'd1);
            check("to_bus_err", 32'(ERR), 32'd0);
        end
        @(posedge CLK); #1;
        idle_inputs();
        @(negedge CLK);
        check("to_err", 32'(ERR), 32'd1);
        check("to_bus_valid_drop", 32'(BUS_VALID), 32'd0);
        check("to_stall", 32'(STALL), 32'd0);
        check("to_rd", 32'(REG_W_RD), 32'd0);
        @(posedge CLK); #1;
        @(negedge CLK);
        check("to_err_pulse", 32'(ERR), 32'd0);
`endif

        for (int t = 0; t < 40; t++) begin
            bit          ld;
            int          dly;
            int          fl;
            logic [31:0] a;
            ld  = 1'($urandom_range(0, 1));
            dly = $urandom_range(0, 4);
            fl  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, dly) : -1;
            a   = {$urandom, 2'b00} & 32'hFFFF_FFFC;
            run_req("rand", ld, 1'b0, 5'($urandom_range(1, 31)), a, 4'($urandom),
                    $urandom, 1'($urandom_range(0, 1)), $urandom, dly, fl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
